fsmc_cfg_receiver: RTL and testbench

//  MCU->FPGA write path of the FSMC link: decodes asynchronous FSMC write cycles into a staging

---
 rtl/fsmc_cfg_receiver_if.sv | 13 +
 rtl/fsmc_cfg_receiver.sv | 214 +++++++++++++++++++++
 tb/tb_fsmc_cfg_receiver.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fsmc_cfg_receiver_if.sv
// FSMC write-side bus from the MCU: chip select, write enable, word address and write data.
// All signals are asynchronous to the FPGA clock.
interface fsmc_cfg_receiver_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              FPGA_NE;
  logic              FPGA_WE;
  logic [ADDR_W-1:0] FSMC_A;
  logic [15:0]       FSMC_D_IN;

  modport master (output FPGA_NE, output FPGA_WE, output FSMC_A, output FSMC_D_IN);
  modport slave  (input  FPGA_NE, input  FPGA_WE, input  FSMC_A, input  FSMC_D_IN);
endinterface

// File: rtl/fsmc_cfg_receiver.sv
// FSMC MCU->FPGA write path: synchronises asynchronous write cycles into a staging bank and,
// on a validated START, copies staging into the active bank with a one-cycle start strobe.
module fsmc_cfg_receiver #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DEF_PSTART  = 6400000,
  parameter int unsigned DEF_PWIDTH  = 10,
  parameter int unsigned DEF_PPERIOD = 23,
  parameter int unsigned DEF_PCOUNT  = 2,
  parameter int unsigned MAX_CAPLEN  = 15000
) (
  input  logic                      clk_80mhz,
  input  logic                      rst,
  fsmc_cfg_receiver_if.slave        bus,
  input  logic                      meas_active,
  output logic [23:0]               pstart,
  output logic [7:0]                pwidth,
  output logic [7:0]                pperiod,
  output logic [3:0]                pcount,
  output logic [13:0]               cap_len,
  output logic                      start_strb,
  output logic                      abort_strb,
  output logic [7:0]                cfg_seq,
  output logic [7:0]                err_cnt
);

  typedef enum logic [1:0] {IDLE, WR_LOW, COMMIT, CHECK} state_t;

  state_t            state_q, state_d;
  logic              ne_m_q, ne_m_d, ne_s_q, ne_s_d;
  logic              we_m_q, we_m_d, we_s_q, we_s_d, we_p_q, we_p_d;
  logic [1:0]        flush_q, flush_d;
  logic              ready_q, ready_d, armed_q, armed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              ctrl_start_q, ctrl_start_d, ctrl_abort_q, ctrl_abort_d;
  logic [23:0]       stg_pstart_q, stg_pstart_d, act_pstart_q, act_pstart_d;
  logic [7:0]        stg_pwidth_q, stg_pwidth_d, act_pwidth_q, act_pwidth_d;
  logic [7:0]        stg_pperiod_q, stg_pperiod_d, act_pperiod_q, act_pperiod_d;
  logic [3:0]        stg_pcount_q, stg_pcount_d, act_pcount_q, act_pcount_d;
  logic [13:0]       stg_caplen_q, stg_caplen_d, act_caplen_q, act_caplen_d;
  logic              start_strb_q, start_strb_d, abort_strb_q, abort_strb_d;
  logic [7:0]        cfg_seq_q, cfg_seq_d, err_cnt_q, err_cnt_d;
  logic              reject;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign reject = meas_active || (stg_pwidth_q == '0) || (stg_pperiod_q <= stg_pwidth_q) ||
                  (stg_pcount_q == '0) || (stg_caplen_q == '0) ||
                  (stg_caplen_q > 14'(MAX_CAPLEN));

  always_comb begin
    state_d       = state_q;
    ne_m_d        = bus.FPGA_NE;
    ne_s_d        = ne_m_q;
    we_m_d        = bus.FPGA_WE;
    we_s_d        = we_m_q;
    we_p_d        = we_s_q;
    flush_d       = {flush_q[0], 1'b1};
    // Arming waits until a genuine high WE is seen after the synchronisers flush,
    // so a WE held low through reset release cannot look like a fresh write.
    ready_d       = ready_q || ((flush_q == 2'b11) && we_s_q);
    armed_d       = armed_q;
    addr_d        = addr_q;
    data_d        = data_q;
    ctrl_start_d  = ctrl_start_q;
    ctrl_abort_d  = ctrl_abort_q;
    stg_pstart_d  = stg_pstart_q;
    stg_pwidth_d  = stg_pwidth_q;
    stg_pperiod_d = stg_pperiod_q;
    stg_pcount_d  = stg_pcount_q;
    stg_caplen_d  = stg_caplen_q;
    act_pstart_d  = act_pstart_q;
    act_pwidth_d  = act_pwidth_q;
    act_pperiod_d = act_pperiod_q;
    act_pcount_d  = act_pcount_q;
    act_caplen_d  = act_caplen_q;
    start_strb_d  = 1'b0;
    abort_strb_d  = 1'b0;
    cfg_seq_d     = cfg_seq_q;
    err_cnt_d     = err_cnt_q;

    if (!we_s_q && !ne_s_q) begin
      addr_d = bus.FSMC_A;
      data_d = bus.FSMC_D_IN;
    end

    unique case (state_q)
      IDLE: begin
        if (ready_q && we_p_q && !we_s_q && !ne_s_q) begin
          armed_d = 1'b1;
          state_d = WR_LOW;
        end
      end
      WR_LOW: begin
        if (we_s_q) begin
          state_d = COMMIT;
          if (armed_q) begin
            armed_d      = 1'b0;
            ctrl_start_d = 1'b0;
            ctrl_abort_d = 1'b0;
            case (addr_q)
              ADDR_W'(0): begin
                ctrl_start_d = data_q[0];
                ctrl_abort_d = data_q[1];
              end
              ADDR_W'(1): stg_pstart_d[15:0]  = data_q;
              ADDR_W'(2): stg_pstart_d[23:16] = data_q[7:0];
              ADDR_W'(3): stg_pwidth_d        = data_q[7:0];
              ADDR_W'(4): stg_pperiod_d       = data_q[7:0];
              ADDR_W'(5): stg_pcount_d        = data_q[3:0];
              ADDR_W'(6): stg_caplen_d        = data_q[13:0];
              default:    err_cnt_d           = sat_inc(err_cnt_q);
            endcase
          end
        end
      end
      COMMIT: begin
        state_d = (addr_q == '0) ? CHECK : IDLE;
      end
      CHECK: begin
        state_d = IDLE;
        if (ctrl_abort_q) begin
          abort_strb_d = 1'b1;
        end else if (ctrl_start_q) begin
          if (reject) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end else begin
            act_pstart_d  = stg_pstart_q;
            act_pwidth_d  = stg_pwidth_q;
            act_pperiod_d = stg_pperiod_q;
            act_pcount_d  = stg_pcount_q;
            act_caplen_d  = stg_caplen_q;
            start_strb_d  = 1'b1;
            cfg_seq_d     = cfg_seq_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_80mhz) begin
    if (rst) begin
      state_q       <= IDLE;
      ne_m_q        <= 1'b1;
      ne_s_q        <= 1'b1;
      we_m_q        <= 1'b1;
      we_s_q        <= 1'b1;
      we_p_q        <= 1'b1;
      flush_q       <= '0;
      ready_q       <= 1'b0;
      armed_q       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      ctrl_start_q  <= 1'b0;
      ctrl_abort_q  <= 1'b0;
      stg_pstart_q  <= 24'(DEF_PSTART);
      stg_pwidth_q  <= 8'(DEF_PWIDTH);
      stg_pperiod_q <= 8'(DEF_PPERIOD);
      stg_pcount_q  <= 4'(DEF_PCOUNT);
      stg_caplen_q  <= 14'(MAX_CAPLEN);
      act_pstart_q  <= 24'(DEF_PSTART);
      act_pwidth_q  <= 8'(DEF_PWIDTH);
      act_pperiod_q <= 8'(DEF_PPERIOD);
      act_pcount_q  <= 4'(DEF_PCOUNT);
      act_caplen_q  <= 14'(MAX_CAPLEN);
      start_strb_q  <= 1'b0;
      abort_strb_q  <= 1'b0;
      cfg_seq_q     <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      ne_m_q        <= ne_m_d;
      ne_s_q        <= ne_s_d;
      we_m_q        <= we_m_d;
      we_s_q        <= we_s_d;
      we_p_q        <= we_p_d;
      flush_q       <= flush_d;
      ready_q       <= ready_d;
      armed_q       <= armed_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      ctrl_start_q  <= ctrl_start_d;
      ctrl_abort_q  <= ctrl_abort_d;
      stg_pstart_q  <= stg_pstart_d;
      stg_pwidth_q  <= stg_pwidth_d;
      stg_pperiod_q <= stg_pperiod_d;
      stg_pcount_q  <= stg_pcount_d;
      stg_caplen_q  <= stg_caplen_d;
      act_pstart_q  <= act_pstart_d;
      act_pwidth_q  <= act_pwidth_d;
      act_pperiod_q <= act_pperiod_d;
      act_pcount_q  <= act_pcount_d;
      act_caplen_q  <= act_caplen_d;
      start_strb_q  <= start_strb_d;
      abort_strb_q  <= abort_strb_d;
      cfg_seq_q     <= cfg_seq_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign pstart     = act_pstart_q;
  assign pwidth     = act_pwidth_q;
  assign pperiod    = act_pperiod_q;
  assign pcount     = act_pcount_q;
  assign cap_len    = act_caplen_q;
  assign start_strb = start_strb_q;
  assign abort_strb = abort_strb_q;
  assign cfg_seq    = cfg_seq_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fsmc_cfg_receiver.sv
// Directed bench for fsmc_cfg_receiver: FSMC write cycles driven on the bus interface,
// strobes counted in a fixed window after each write, outputs compared to hand-derived values.
module tb_fsmc_cfg_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        meas_active;
  logic [23:0] pstart;
  logic [7:0]  pwidth, pperiod, cfg_seq, err_cnt;
  logic [3:0]  pcount;
  logic [13:0] cap_len;
  logic        start_strb, abort_strb;

  int n_checks = 0;
  int n_errors = 0;
  int ns, na;

  always #6 clk = ~clk;

  fsmc_cfg_receiver_if #(.ADDR_W(3)) bus ();

  fsmc_cfg_receiver #(.ADDR_W(3)) dut (
    .clk_80mhz  (clk),
    .rst        (rst),
    .bus        (bus),
    .meas_active(meas_active),
    .pstart     (pstart),
    .pwidth     (pwidth),
    .pperiod    (pperiod),
    .pcount     (pcount),
    .cap_len    (cap_len),
    .start_strb (start_strb),
    .abort_strb (abort_strb),
    .cfg_seq    (cfg_seq),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One FSMC write; WE and NE rise together, strobe cycles are counted over a bounded window.
  task automatic wr(input int a, input int d, input int low, output int s_cnt, output int a_cnt);
    @(negedge clk);
    bus.FSMC_A    = 3'(a);
    bus.FSMC_D_IN = 16'(d);
    bus.FPGA_NE   = 1'b0;
    bus.FPGA_WE   = 1'b0;
    repeat (low) @(negedge clk);
    bus.FPGA_WE = 1'b1;
    bus.FPGA_NE = 1'b1;
    s_cnt = 0;
    a_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      s_cnt += int'(start_strb);
      a_cnt += int'(abort_strb);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bus.FPGA_NE = 1'b1;
    bus.FPGA_WE = 1'b1;
    bus.FSMC_A = '0;
    bus.FSMC_D_IN = '0;
    meas_active = 1'b0;
    do_reset();

    check("rst_pstart",  pstart, 6400000);
    check("rst_pwidth",  pwidth, 10);
    check("rst_pperiod", pperiod, 23);
    check("rst_pcount",  pcount, 2);
    check("rst_caplen",  cap_len, 15000);
    check("rst_start",   start_strb, 0);
    check("rst_abort",   abort_strb, 0);
    check("rst_seq",     cfg_seq, 0);
    check("rst_err",     err_cnt, 0);

    wr(1, 'h1234, 6, ns, na);
    check("pst_lo_nostrb", ns, 0);
    check("pst_lo_hold",   pstart, 6400000);
    wr(2, 'h0061, 6, ns, na);
    wr(0, 1, 6, ns, na);
    check("start1_strb",  ns, 1);
    check("start1_pst",   pstart, 'h611234);
    check("start1_seq",   cfg_seq, 1);
    check("start1_err",   err_cnt, 0);

    wr(6, 15001, 6, ns, na);
    wr(0, 1, 6, ns, na);
    check("caplen_hi_strb", ns, 0);
    check("caplen_hi_err",  err_cnt, 1);
    check("caplen_hi_keep", cap_len, 15000);

    wr(6, 15000, 6, ns, na);
    wr(5, 7, 6, ns, na);
    wr(0, 1, 6, ns, na);
    check("caplen_max_strb", ns, 1);
    check("caplen_max_cnt",  pcount, 7);
    check("caplen_max_seq",  cfg_seq, 2);

    meas_active = 1'b1;
    wr(0, 1, 6, ns, na);
    check("meas_strb", ns, 0);
    check("meas_err",  err_cnt, 2);
    wr(0, 3, 6, ns, na);
    check("abort_strb",   na, 1);
    check("abort_nostrt", ns, 0);
    check("abort_err",    err_cnt, 2);
    check("abort_seq",    cfg_seq, 2);
    meas_active = 1'b0;

    wr(4, 10, 6, ns, na);
    wr(0, 1, 6, ns, na);
    check("per_eq_wid_strb", ns, 0);
    check("per_eq_wid_err",  err_cnt, 3);
    check("per_keep",        pperiod, 23);
    wr(4, 23, 6, ns, na);
    wr(7, 5, 6, ns, na);
    check("reserved_err", err_cnt, 4);

    // WE and NE held low across reset release, then released.
    @(negedge clk);
    bus.FSMC_A = 3'd3;
    bus.FSMC_D_IN = 16'd99;
    bus.FPGA_NE = 1'b0;
    bus.FPGA_WE = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    bus.FPGA_WE = 1'b1;
    bus.FPGA_NE = 1'b1;
    repeat (10) @(negedge clk);
    check("we_rst_pst", pstart, 6400000);
    wr(0, 1, 6, ns, na);
    check("we_rst_strb",  ns, 1);
    check("we_rst_width", pwidth, 10);
    check("we_rst_seq",   cfg_seq, 1);

    wr(3, 7, 2, ns, na);
    wr(0, 1, 6, ns, na);
    check("short_we_width", ((pwidth == 8'd10) || (pwidth == 8'd7)) ? 1 : 0, 1);
    check("short_we_per",   pperiod, 23);

    do_reset();
    meas_active = 1'b1;
    for (int i = 0; i < 300; i++) wr(0, 1, 5, ns, na);
    check("err_sat", err_cnt, 255);
    meas_active = 1'b0;
    for (int i = 0; i < 255; i++) wr(0, 1, 5, ns, na);
    check("seq_255", cfg_seq, 255);
    wr(0, 1, 5, ns, na);
    check("seq_wrap_strb", ns, 1);
    check("seq_wrap",      cfg_seq, 0);
    check("seq_wrap_err",  err_cnt, 255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
